// File: rtl/meas_vote.sv
// meas_vote: PUF measurement front-end with per-cell majority voting.
//
// After each release of the measurement reset (I_meas_rst falling), the
// block waits SETTLE_CYCLES cycles for the cells to settle. It then samples
// the synchronised cell outputs 2^SAMPLE_BITS times and counts the ones seen
// for each cell. The response bit for a cell is 1 only when its ones-count
// is strictly greater than half the sample count, so a tie votes 0. The
// voted word is offered downstream on a valid/ready handshake.
//
// Ports:
//   I_clk       single clock
//   I_rst       synchronous active-high reset, highest priority
//   I_meas_rst  measurement reset from the controller (already synchronous);
//               high holds the cells in reset
//   I_cells     raw, asynchronous PUF cell outputs
//   I_ready     downstream accepts the word
//   O_data      voted response word
//   O_valid     O_data is valid
//   O_busy      high while settling or sampling
//   O_abort     one-cycle pulse: measurement discarded
//   O_drop      one-cycle pulse: a release arrived in HOLD and was ignored
//
// Handshake: O_valid rises with O_data already stable. O_valid and O_data
// hold unchanged until an edge where O_valid and I_ready are both high.
// That edge completes the transfer, and O_valid is low after it.
module meas_vote #(
    parameter int CELL_BITS     = 8,
    parameter int SAMPLE_BITS   = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_meas_rst,
    input  logic [CELL_BITS-1:0] I_cells,
    input  logic                 I_ready,
    output logic [CELL_BITS-1:0] O_data,
    output logic                 O_valid,
    output logic                 O_busy,
    output logic                 O_abort,
    output logic                 O_drop
);

    localparam int CNT_W       = SAMPLE_BITS + 1;
    localparam int NUM_SAMPLES = 1 << SAMPLE_BITS;

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0] HALF        = CNT_W'(NUM_SAMPLES / 2);
    localparam logic [15:0]      LAST_SETTLE = 16'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } state_t;

    state_t               state;
    logic [CELL_BITS-1:0] sync_meta;
    logic [CELL_BITS-1:0] sync_cells;
    logic                 prev;
    logic                 rel;
    logic [15:0]          settle_cnt;
    logic [CNT_W-1:0]     sample_cnt;
    logic [CNT_W-1:0]     ones [CELL_BITS];
    logic [CELL_BITS-1:0] vote;

    // A release is a 1->0 step of the measurement reset. prev clears to 0,
    // so a low I_meas_rst coming out of I_rst is not a release.
    assign rel = prev & ~I_meas_rst;

    assign O_busy = (state == ST_SETTLE) || (state == ST_SAMPLE);

    // Strict majority: a tie (exactly half ones) votes 0.
    always_comb begin
        vote = '0;
        for (int i = 0; i < CELL_BITS; i++) begin
            vote[i] = (ones[i] > HALF);
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state      <= ST_IDLE;
            sync_meta  <= '0;
            sync_cells <= '0;
            prev       <= 1'b0;
            settle_cnt <= '0;
            sample_cnt <= '0;
            for (int i = 0; i < CELL_BITS; i++) begin
                ones[i] <= '0;
            end
            O_data  <= '0;
            O_valid <= 1'b0;
            O_abort <= 1'b0;
            O_drop  <= 1'b0;
        end else begin
            sync_meta  <= I_cells;
            sync_cells <= sync_meta;
            prev       <= I_meas_rst;
            O_abort    <= 1'b0;
            O_drop     <= 1'b0;

            if (O_busy && I_meas_rst) begin
                // The cells were put back into reset mid-measurement. The
                // partial result is discarded, and O_data keeps the last word.
                O_abort    <= 1'b1;
                state      <= ST_IDLE;
                settle_cnt <= '0;
                sample_cnt <= '0;
                for (int i = 0; i < CELL_BITS; i++) begin
                    ones[i] <= '0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rel) begin
                            state      <= ST_SETTLE;
                            settle_cnt <= '0;
                            sample_cnt <= '0;
                            for (int i = 0; i < CELL_BITS; i++) begin
                                ones[i] <= '0;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        settle_cnt <= settle_cnt + 16'd1;
                        if (settle_cnt == LAST_SETTLE) begin
                            state <= ST_SAMPLE;
                        end
                    end
                    ST_SAMPLE: begin
                        for (int i = 0; i < CELL_BITS; i++) begin
                            ones[i] <= ones[i] + CNT_W'(sync_cells[i]);
                        end
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        if (sample_cnt == LAST_SAMPLE) begin
                            state <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        // Releases are never queued behind a pending word,
                        // including one that lands on the transfer edge.
                        if (rel) begin
                            O_drop <= 1'b1;
                        end
                        // The first HOLD cycle registers the vote from the
                        // completed ones-counters. Later cycles wait for the
                        // handshake.
                        if (!O_valid) begin
                            O_data  <= vote;
                            O_valid <= 1'b1;
                        end else if (I_ready) begin
                            O_valid <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_meas_vote.sv
// tb_meas_vote: self-checking bench for meas_vote with default parameters.
// Each measurement is described by a 16-entry pattern of cell words, one per
// sample. The expected response is computed by counting ones per bit over
// that pattern. Outside the sample window, random noise is driven on the
// cells.
module tb_meas_vote;

    localparam int W = 8;
    localparam int S = 16;
    localparam int N = 16;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         meas_rst = 1'b0;
    logic         ready    = 1'b0;
    logic [W-1:0] cells    = '0;
    logic [W-1:0] data;
    logic         valid;
    logic         busy;
    logic         abort_p;
    logic         drop_p;

    meas_vote #(
        .CELL_BITS    (W),
        .SAMPLE_BITS  (4),
        .SETTLE_CYCLES(S)
    ) dut (
        .I_clk     (clk),
        .I_rst     (rst),
        .I_meas_rst(meas_rst),
        .I_cells   (cells),
        .I_ready   (ready),
        .O_data    (data),
        .O_valid   (valid),
        .O_busy    (busy),
        .O_abort   (abort_p),
        .O_drop    (drop_p)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int           total      = 0;
    int           bad        = 0;
    int           cyc        = 0;
    int           rel_edge   = 0;
    int           drop_seen  = 0;
    int           abort_seen = 0;
    logic         noise      = 1'b1;
    logic [W-1:0] pat [N];
    logic [W-1:0] last_data  = '0;
    logic [W-1:0] exp_q [$];

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one edge; sample #1 later and tally pulse outputs.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (drop_p) drop_seen++;
        if (abort_p) abort_seen++;
    endtask

    // Drive the cell word that the next edge (cyc+1) will capture. Sample j
    // (1-based) is taken at edge rel_edge+S+j through two sync flops. That
    // sample therefore uses the word captured at edge rel_edge+S+j-2.
    task automatic drive_cells();
        int idx = cyc + 1 - (rel_edge + S - 1);
        if (idx >= 0 && idx < N) cells = pat[idx];
        else if (noise) cells = W'($urandom);
        else cells = pat[0];
    endtask

    task automatic fill_random();
        for (int j = 0; j < N; j++) pat[j] = W'($urandom);
    endtask

    // Reference vote: count ones per cell across the samples; strict majority.
    function automatic logic [W-1:0] vote_model();
        logic [W-1:0] r;
        r = '0;
        for (int b = 0; b < W; b++) begin
            int c;
            c = 0;
            for (int j = 0; j < N; j++) c += int'(pat[j][b]);
            r[b] = (c > N / 2);
        end
        return r;
    endfunction

    // Drive I_meas_rst 1 then 0. The 0 is seen at edge rel_edge.
    task automatic release_meas();
        rel_edge = cyc + 2;
        meas_rst = 1'b1;
        drive_cells();
        step();
        meas_rst = 1'b0;
        drive_cells();
        step();
        check("busy_at_release", busy, 1);
    endtask

    // ---------------- driver tasks ----------------
    task automatic measure_run(input int ready_wait, input int drop_at, input bit rel_at_xfer);
        logic [W-1:0] exp_data;
        int           exp_drops;
        exp_q.push_back(vote_model());
        ready = (ready_wait == 0);
        release_meas();
        abort_seen = 0;
        for (int k = 1; k <= S + N; k++) begin
            drive_cells();
            step();
            check("busy_window", busy, (k <= S + N - 1));
            check("valid_early", valid, 0);
        end
        drive_cells();
        step();
        exp_data = exp_q.pop_front();
        check("valid_rise", valid, 1);
        check("data_vote", data, exp_data);
        check("busy_in_hold", busy, 0);
        drop_seen = 0;
        for (int d = 0; d < ready_wait; d++) begin
            meas_rst = (d == drop_at) || (rel_at_xfer && d == ready_wait - 1);
            drive_cells();
            step();
            check("valid_hold", valid, 1);
            check("data_hold", data, exp_data);
        end
        ready    = 1'b1;
        meas_rst = 1'b0;
        drive_cells();
        step();
        check("valid_after_xfer", valid, 0);
        drive_cells();
        step();
        check("busy_after_xfer", busy, 0);
        check("valid_idle", valid, 0);
        check("data_kept", data, exp_data);
        exp_drops = ((drop_at >= 0) ? 1 : 0) + (rel_at_xfer ? 1 : 0);
        check("drop_count", drop_seen, exp_drops);
        check("abort_count_run", abort_seen, 0);
        last_data = exp_data;
    endtask

    task automatic abort_run(input int abort_at);
        fill_random();
        release_meas();
        abort_seen = 0;
        drop_seen  = 0;
        for (int k = 1; k < abort_at; k++) begin
            drive_cells();
            step();
        end
        meas_rst = 1'b1;
        drive_cells();
        step();
        check("abort_pulse", abort_p, 1);
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_data", data, last_data);
        for (int k = 0; k < 3; k++) begin
            drive_cells();
            step();
            check("abort_valid_after", valid, 0);
            check("abort_busy_after", busy, 0);
        end
        check("abort_count", abort_seen, 1);
        check("abort_drop_count", drop_seen, 0);
        check("abort_data_after", data, last_data);
    endtask

    task automatic reset_run(input int rst_at);
        fill_random();
        ready = 1'b0;
        release_meas();
        abort_seen = 0;
        drop_seen  = 0;
        for (int k = 1; k < rst_at; k++) begin
            drive_cells();
            step();
        end
        if (rst_at > S + N + 1) check("hold_before_rst", valid, 1);
        rst = 1'b1;
        drive_cells();
        step();
        rst = 1'b0;
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_abort", abort_p, 0);
        check("rst_drop", drop_p, 0);
        for (int k = 0; k < 20; k++) begin
            drive_cells();
            step();
        end
        check("rst_busy_later", busy, 0);
        check("rst_valid_later", valid, 0);
        check("rst_abort_count", abort_seen, 0);
        check("rst_drop_count", drop_seen, 0);
        last_data = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        step();
        step();
        check("reset_data", data, 0);
        check("reset_valid", valid, 0);
        check("reset_busy", busy, 0);
        check("reset_abort", abort_p, 0);
        check("reset_drop", drop_p, 0);
        rst = 1'b0;
        drive_cells();
        step();

        // Constant 8'hA5 on the cells, immediate transfer.
        for (int j = 0; j < N; j++) pat[j] = 8'hA5;
        noise = 1'b0;
        measure_run(0, -1, 1'b0);
        check("const_a5", data, 8'hA5);
        noise = 1'b1;

        // 9/8/7 ones on bits 0/1/2: only bit 0 wins, and the tie on bit 1 votes 0.
        for (int j = 0; j < N; j++) pat[j] = {5'b0, (j < 7), (j < 8), (j < 9)};
        measure_run(0, -1, 1'b0);
        check("tie_vote", data, 8'h01);

        // Backpressure with a release during HOLD.
        fill_random();
        measure_run(10, 2, 1'b0);

        // Release on the transfer edge is dropped too.
        fill_random();
        measure_run(4, -1, 1'b1);

        // Aborts in SETTLE (cycle 5) and at sample 7, each followed by a good run.
        abort_run(5);
        fill_random();
        measure_run(0, -1, 1'b0);
        abort_run(S + 7);
        fill_random();
        measure_run(1, -1, 1'b0);

        // Reset mid-SAMPLE and mid-HOLD.
        reset_run(S + 4);
        fill_random();
        measure_run(0, -1, 1'b0);
        reset_run(S + N + 4);
        fill_random();
        measure_run(2, -1, 1'b0);

        // Reset released with I_meas_rst already low: no false start.
        meas_rst = 1'b1;
        rst      = 1'b1;
        drive_cells();
        step();
        drive_cells();
        step();
        meas_rst = 1'b0;
        drive_cells();
        step();
        rst = 1'b0;
        last_data = '0;
        for (int k = 0; k < 30; k++) begin
            drive_cells();
            step();
            check("no_false_start", busy, 0);
        end
        check("no_false_valid", valid, 0);
        fill_random();
        measure_run(0, -1, 1'b0);

        // Random measurements with random backpressure.
        for (int t = 0; t < 6; t++) begin
            fill_random();
            measure_run(int'($urandom_range(0, 5)), -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
